encoder_4to2: RTL and testbench
===============================

Name: encoder_4to2

Overview:
Registered 4-to-2 priority encoder with valid and multi-hot flags. Converts a 4-bit request vector into the 2-bit index of its highest set bit. Used as a small arbitration/index-encode stage between request-collection logic and downstream selectors. Single clock domain, one-cycle latency.

Parameters:
None. Input width is fixed at 4 and output width at 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; when 0, registered outputs hold their values
in  input  4  request vector; bit i set means request i is active
out  output  2  index of the highest set bit of in, registered
vld  output  1  registered; 1 when the captured in was non-zero
multi  output  1  registered; 1 when the captured in had two or more bits set

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n=0: out=2'b00, vld=0, multi=0, immediately and independent of clk.
  - Reset release is synchronous in effect: the first capture occurs on the first rising clk edge with rst_n=1 and en=1.
- On each rising clk edge with rst_n=1 and en=1, out, vld and multi load from the combinational encode of in.
- On each rising clk edge with en=0, all outputs hold.
- Latency: exactly one cycle from in to out/vld/multi. No combinational path from in to any output.
- Encode rule, highest index wins:
  - in[3]=1 -> out=11
  - else in[2]=1 -> out=10
  - else in[1]=1 -> out=01
  - else in[0]=1 -> out=00
  - in=0000 -> out=00, vld=0
- vld = OR of all in bits.
- multi = 1 iff the popcount of in is >= 2.
- One-hot inputs give multi=0. Examples: 0001->00, 0010->01, 0100->10, 1000->11.
- Multi-hot examples: 0111->10, multi=1; 1010->11, multi=1; 1111->11, multi=1.
- out=00 is ambiguous between in=0001 and in=0000. Consumers must qualify out with vld.
- If reset is asserted mid-stream, outputs clear at once. Any capture pending on the same edge is discarded.
- X/Z on in is not required to be handled. Behaviour for X/Z inputs is undefined.

Optional Feature:
Macro ENC_STICKY_ERR_EN.
- When defined, two extra ports are added:
  - err_clr  input  1  synchronous clear of the sticky flag
  - err_sticky  output  1  sticky multi-hot error flag
- err_sticky sets to 1 on any clk edge where a capture occurs (en=1) and the captured in is multi-hot.
- err_sticky stays at 1 until cleared.
- err_clr=1 on a clk edge clears err_sticky to 0.
  - If err_clr and a multi-hot capture occur on the same edge, set wins and err_sticky=1.
- rst_n=0 clears err_sticky asynchronously.
- When the macro is not defined, neither port exists and no sticky register is built. All other behaviour is identical.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with in=1111 -> out=00, vld=0, multi=0 immediately, without waiting for a clk edge.
2. One-hot sweep with en=1: in=0001, 0010, 0100, 1000 on consecutive cycles -> one cycle later out=00, 01, 10, 11 respectively; vld=1 and multi=0 for all four.
3. Zero input: in=0000 -> next cycle out=00, vld=0, multi=0.
4. Priority on multi-hot: in=0111, 1010, 1111 -> out=10, 11, 11 respectively, with vld=1 and multi=1 for each.
5. Enable hold: capture in=0100 (out=10), then set en=0 and in=1000 for 3 cycles -> out stays 10, vld stays 1; then set en=1 -> out=11 one cycle later.
6. Sticky error (with ENC_STICKY_ERR_EN defined):
   - Capture in=1010 -> err_sticky=1.
   - Apply one-hot inputs -> err_sticky remains 1.
   - Pulse err_clr -> err_sticky=0.
   - Assert err_clr on the same edge as capturing in=0011 -> err_sticky=1.

Source files
------------

// File: rtl/encoder_4to2.sv
// Registered 4-to-2 priority encoder (highest set bit wins) with valid and multi-hot flags.
// Define ENC_STICKY_ERR_EN to add a sticky multi-hot error flag (err_clr / err_sticky).
module encoder_4to2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] in,
`ifdef ENC_STICKY_ERR_EN
  input  logic       err_clr,
  output logic       err_sticky,
`endif
  output logic [1:0] out,
  output logic       vld,
  output logic       multi
);

  logic [1:0] w_out;
  logic       w_vld;
  logic       w_multi;

  logic [1:0] r_out;
  logic       r_vld;
  logic       r_multi;

  always_comb begin
    w_out = 2'b00;
    if (in[3])      w_out = 2'b11;
    else if (in[2]) w_out = 2'b10;
    else if (in[1]) w_out = 2'b01;
    else            w_out = 2'b00;
  end

  assign w_vld   = |in;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi = |(in & (in - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= 2'b00;
      r_vld   <= 1'b0;
      r_multi <= 1'b0;
    end else if (en) begin
      r_out   <= w_out;
      r_vld   <= w_vld;
      r_multi <= w_multi;
    end
  end

  assign out   = r_out;
  assign vld   = r_vld;
  assign multi = r_multi;

`ifdef ENC_STICKY_ERR_EN
  logic r_err_sticky;

  // A multi-hot capture on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sticky <= 1'b0;
    end else if (en && w_multi) begin
      r_err_sticky <= 1'b1;
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_encoder_4to2.sv
// Self-checking bench for encoder_4to2: directed vector table, hand-written reset/hold/sticky
// sequences, and randomized stimulus against a behavioural model. Honours ENC_STICKY_ERR_EN.
module tb_encoder_4to2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] in_v;
  logic [1:0] out_v;
  logic       vld;
  logic       multi;
`ifdef ENC_STICKY_ERR_EN
  logic       err_clr;
  logic       err_sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  encoder_4to2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in        (in_v),
`ifdef ENC_STICKY_ERR_EN
    .err_clr   (err_clr),
    .err_sticky(err_sticky),
`endif
    .out       (out_v),
    .vld       (vld),
    .multi     (multi)
  );

  typedef struct {
    logic       en;
    logic [3:0] in;
    logic [1:0] e_out;
    logic       e_vld;
    logic       e_multi;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] e_out, input logic e_vld,
                            input logic e_multi);
    check({name, ".out"},   {6'd0, out_v}, {6'd0, e_out});
    check({name, ".vld"},   {7'd0, vld},   {7'd0, e_vld});
    check({name, ".multi"}, {7'd0, multi}, {7'd0, e_multi});
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: highest set bit index, non-zero, and bit count >= 2.
  function automatic int model_idx(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int model_pop(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  initial begin
    logic [1:0] m_out;
    logic       m_vld;
    logic       m_multi;
    logic       m_err;

    vecs[0]  = '{1'b1, 4'b0001, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b0010, 2'b01, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b0100, 2'b10, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b1000, 2'b11, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b0000, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b0111, 2'b10, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 4'b1010, 2'b11, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 4'b1111, 2'b11, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'b0001, 2'b11, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'b0011, 2'b01, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'b0000, 2'b01, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 4'b0101, 2'b10, 1'b1, 1'b1};

    rst_n = 1'b0;
    en    = 1'b0;
    in_v  = 4'b1111;
`ifdef ENC_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    #2;
    check_outs("reset_initial", 2'b00, 1'b0, 1'b0);
    step();
    step();
    check_outs("reset_held", 2'b00, 1'b0, 1'b0);

    // Release between edges; capture 1111 then assert reset mid-cycle.
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    check_outs("first_capture", 2'b11, 1'b1, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset_midcycle", 2'b00, 1'b0, 1'b0);
    step();
    check_outs("reset_discards_capture", 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      en   = vecs[i].en;
      in_v = vecs[i].in;
      step();
      check_outs($sformatf("vec%0d_in%b_en%b", i, vecs[i].in, vecs[i].en),
                 vecs[i].e_out, vecs[i].e_vld, vecs[i].e_multi);
    end

    // Enable hold: capture 0100, hold for three cycles with 1000 presented, then release.
    en   = 1'b1;
    in_v = 4'b0100;
    step();
    check_outs("hold_load", 2'b10, 1'b1, 1'b0);
    en   = 1'b0;
    in_v = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs($sformatf("hold_cyc%0d", i), 2'b10, 1'b1, 1'b0);
    end
    en = 1'b1;
    step();
    check_outs("hold_release", 2'b11, 1'b1, 1'b0);

`ifdef ENC_STICKY_ERR_EN
    // Reset clears the flag asynchronously.
    in_v = 4'b1010;
    step();
    check("sticky_set", {7'd0, err_sticky}, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("sticky_async_reset", {7'd0, err_sticky}, 8'd0);
    step();
    rst_n = 1'b1;
    in_v = 4'b1010;
    step();
    check("sticky_set_1010", {7'd0, err_sticky}, 8'd1);
    in_v = 4'b0001;
    step();
    in_v = 4'b0100;
    step();
    check("sticky_holds_onehot", {7'd0, err_sticky}, 8'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("sticky_cleared", {7'd0, err_sticky}, 8'd0);
    in_v = 4'b0010;
    step();
    check("sticky_stays_clear", {7'd0, err_sticky}, 8'd0);
    err_clr = 1'b1;
    in_v    = 4'b0011;
    step();
    err_clr = 1'b0;
    check("sticky_set_wins", {7'd0, err_sticky}, 8'd1);
    en   = 1'b0;
    in_v = 4'b1111;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("sticky_clr_no_capture", {7'd0, err_sticky}, 8'd0);
    en = 1'b1;
`endif

    // Randomized run against the model; the model starts from the current register state.
    m_out   = out_v;
    m_vld   = vld;
    m_multi = multi;
`ifdef ENC_STICKY_ERR_EN
    m_err = err_sticky;
`else
    m_err = 1'b0;
`endif
    for (int i = 0; i < 300; i++) begin
      logic [3:0] r_in;
      logic       r_en;
      logic       r_clr;
      r_in  = 4'($urandom_range(0, 15));
      r_en  = ($urandom_range(0, 3) != 0);
      r_clr = ($urandom_range(0, 7) == 0);
      en   = r_en;
      in_v = r_in;
`ifdef ENC_STICKY_ERR_EN
      err_clr = r_clr;
`endif
      if (r_en) begin
        m_out   = 2'(model_idx(r_in));
        m_vld   = (r_in != 4'd0);
        m_multi = (model_pop(r_in) >= 2);
      end
      if (r_en && model_pop(r_in) >= 2) m_err = 1'b1;
      else if (r_clr)                   m_err = 1'b0;
      step();
      check_outs($sformatf("rand%0d_in%b_en%b", i, r_in, r_en), m_out, m_vld, m_multi);
`ifdef ENC_STICKY_ERR_EN
      check($sformatf("rand%0d_sticky", i), {7'd0, err_sticky}, {7'd0, m_err});
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
